// File: rtl/pio_input_pkg.sv
// Shared field layout and helpers for the PIO input conditioner.
// The buttons_o word is described once here so the RTL and any consumer agree on it.
package pio_input_pkg;

  localparam int WORD_W         = 32;
  localparam int KEY_LANES      = 4;
  localparam int LVL_LSB        = 0;
  localparam int PRESS_LSB      = 4;
  localparam int REL_LSB        = 8;
  localparam int OVF_LSB        = 12;
  localparam int SEQ_LSB        = 16;
  localparam int SEQ_W          = 8;
  localparam int ACK_TOGGLE_BIT = 31;

  typedef struct packed {
    logic [7:0]           rsvd;
    logic [SEQ_W-1:0]     seq;
    logic [KEY_LANES-1:0] ovf;
    logic [KEY_LANES-1:0] rel;
    logic [KEY_LANES-1:0] press;
    logic [KEY_LANES-1:0] lvl;
  } buttons_t;

  // Never returns less than 1 so a counter of this width always exists.
  function automatic int clog2(input int value);
    int w;
    int v;
    w = 0;
    v = value - 1;
    while (v > 0) begin
      w = w + 1;
      v = v >> 1;
    end
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/debounce_cell.sv
// One input lane: 2-flop synchronizer, stability counter and accepted level.
// rise_o/fall_o are combinational and fire on the edge where the level is accepted.
module debounce_cell
  import pio_input_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter bit INVERT          = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int              CNT_W    = clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             meta_q, meta_d;
  logic             sync_q, sync_d;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept;

  always_comb begin
    meta_d   = raw_i ^ INVERT;
    sync_d   = meta_q;
    stable_d = stable_q;
    cnt_d    = '0;
    accept   = 1'b0;
    if (sync_q != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        accept   = 1'b1;
        stable_d = sync_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_q   <= 1'b0;
      sync_q   <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      meta_q   <= meta_d;
      sync_q   <= sync_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign level_o = stable_q;
  assign rise_o  = accept & sync_q;
  assign fall_o  = accept & ~sync_q;

endmodule

// File: rtl/pio_input_conditioner.sv
// Debounced keys and switches with sticky press/release/overflow flags,
// cleared by a toggle-handshake acknowledge word from the host.
module pio_input_conditioner
  import pio_input_pkg::*;
#(
  parameter int N_KEYS          = 4,
  parameter int N_SW            = 18,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [N_KEYS-1:0] key_n_i,
  input  logic [N_SW-1:0]   sw_i,
  input  logic [31:0]       ack_word_i,
  output logic [31:0]       buttons_o,
  output logic [31:0]       switches_o,
  output logic              event_pending_o
);

  logic [N_KEYS-1:0]    key_lvl, key_rise, key_fall;
  logic [N_SW-1:0]      sw_lvl, sw_rise_unused, sw_fall_unused;
  logic [KEY_LANES-1:0] lvl_pad, rise_pad, fall_pad;

  for (genvar i = 0; i < N_KEYS; i++) begin : g_key
    debounce_cell #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .INVERT         (1'b1)
    ) u_cell (
      .clk    (clk),
      .reset_n(reset_n),
      .raw_i  (key_n_i[i]),
      .level_o(key_lvl[i]),
      .rise_o (key_rise[i]),
      .fall_o (key_fall[i])
    );
  end

  for (genvar i = 0; i < N_SW; i++) begin : g_sw
    debounce_cell #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .INVERT         (1'b0)
    ) u_cell (
      .clk    (clk),
      .reset_n(reset_n),
      .raw_i  (sw_i[i]),
      .level_o(sw_lvl[i]),
      .rise_o (sw_rise_unused[i]),
      .fall_o (sw_fall_unused[i])
    );
  end

  // Unused key lanes are tied off so their flags can never set.
  assign lvl_pad  = KEY_LANES'(key_lvl);
  assign rise_pad = KEY_LANES'(key_rise);
  assign fall_pad = KEY_LANES'(key_fall);

  logic [KEY_LANES-1:0] press_q, press_d;
  logic [KEY_LANES-1:0] rel_q, rel_d;
  logic [KEY_LANES-1:0] ovf_q, ovf_d;
  logic [SEQ_W-1:0]     seq_q, seq_d;
  logic                 ack_seen_q, ack_seen_d;
  logic                 pending_q, pending_d;
  logic                 ack_toggle;
  logic [KEY_LANES-1:0] clr_press, clr_rel, clr_ovf;

  always_comb begin
    ack_toggle = ack_word_i[ACK_TOGGLE_BIT] != ack_seen_q;
    ack_seen_d = ack_word_i[ACK_TOGGLE_BIT];
    clr_press  = ack_toggle ? ack_word_i[PRESS_LSB +: KEY_LANES] : '0;
    clr_rel    = ack_toggle ? ack_word_i[REL_LSB   +: KEY_LANES] : '0;
    clr_ovf    = ack_toggle ? ack_word_i[OVF_LSB   +: KEY_LANES] : '0;

    // A new event beats a same-cycle clear; a press that lands on a flag being
    // cleared counts as fresh, not as an overflow.
    press_d   = rise_pad | (press_q & ~clr_press);
    rel_d     = fall_pad | (rel_q & ~clr_rel);
    ovf_d     = (rise_pad & press_q & ~clr_press) | (ovf_q & ~clr_ovf);
    seq_d     = seq_q + SEQ_W'(|{rise_pad, fall_pad});
    pending_d = |{press_d, rel_d, ovf_d};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      press_q    <= '0;
      rel_q      <= '0;
      ovf_q      <= '0;
      seq_q      <= '0;
      ack_seen_q <= 1'b0;
      pending_q  <= 1'b0;
    end else begin
      press_q    <= press_d;
      rel_q      <= rel_d;
      ovf_q      <= ovf_d;
      seq_q      <= seq_d;
      ack_seen_q <= ack_seen_d;
      pending_q  <= pending_d;
    end
  end

  buttons_t btn;

  always_comb begin
    btn       = '0;
    btn.lvl   = lvl_pad;
    btn.press = press_q;
    btn.rel   = rel_q;
    btn.ovf   = ovf_q;
    btn.seq   = seq_q;
  end

  assign buttons_o       = btn;
  assign switches_o      = WORD_W'(sw_lvl);
  assign event_pending_o = pending_q;

  logic unused_ack_bits;
  assign unused_ack_bits = ^{ack_word_i[30:16], ack_word_i[3:0]};

endmodule

// File: tb/tb_pio_input_conditioner.sv
// Scoreboard bench: a behavioural model queues expected words with the cycle
// they must appear on; a negedge monitor pops and compares them.
module tb_pio_input_conditioner;

  logic        clk;
  logic        reset_n;
  logic [3:0]  key_n;
  logic [17:0] sw;
  logic [31:0] ack_word;
  logic [31:0] buttons;
  logic [31:0] switches;
  logic        pending;

  pio_input_conditioner #(
    .N_KEYS         (4),
    .N_SW           (18),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .key_n_i        (key_n),
    .sw_i           (sw),
    .ack_word_i     (ack_word),
    .buttons_o      (buttons),
    .switches_o     (switches),
    .event_pending_o(pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          due;
    string       tag;
    int          sel;
    logic [31:0] mask;
    logic [31:0] val;
  } sb_t;

  sb_t sb_q[$];
  int  n_vec = 0;
  int  n_err = 0;

  task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  sb_t         mon_e;
  logic [31:0] mon_obs;
  always @(negedge clk) begin
    while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
      mon_e = sb_q.pop_front();
      case (mon_e.sel)
        0:       mon_obs = buttons;
        1:       mon_obs = switches;
        default: mon_obs = {31'b0, pending};
      endcase
      chk_val(mon_e.tag, mon_obs & mon_e.mask, mon_e.val & mon_e.mask);
    end
  end

  logic [3:0] m_lvl, m_prs, m_rel, m_ovf;
  logic [7:0] m_seq;
  logic       m_ack_seen;

  function automatic logic [31:0] m_word();
    return {8'h00, m_seq, m_ovf, m_rel, m_prs, m_lvl};
  endfunction

  function automatic logic [31:0] m_pend();
    return {31'b0, |{m_prs, m_rel, m_ovf}};
  endfunction

  task automatic m_reset();
    m_lvl = '0; m_prs = '0; m_rel = '0; m_ovf = '0; m_seq = '0; m_ack_seen = 1'b0;
  endtask

  task automatic push(input int due, input string tag, input int sel,
                      input logic [31:0] val, input logic [31:0] mask);
    sb_t e;
    e.due = due; e.tag = tag; e.sel = sel; e.val = val; e.mask = mask;
    sb_q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Raw change driven now is sampled next edge and accepted 1+DEBOUNCE edges later.
  task automatic apply_keys(input logic [3:0] kn, input string tag);
    logic [31:0] old_w;
    logic        ev;
    logic        now_pressed;
    old_w = m_word();
    key_n = kn;
    ev    = 1'b0;
    for (int i = 0; i < 4; i++) begin
      now_pressed = ~kn[i];
      if (now_pressed && !m_lvl[i]) begin
        if (m_prs[i]) m_ovf[i] = 1'b1;
        m_prs[i] = 1'b1;
        ev = 1'b1;
      end else if (!now_pressed && m_lvl[i]) begin
        m_rel[i] = 1'b1;
        ev = 1'b1;
      end
    end
    m_lvl = ~kn;
    if (ev) m_seq = m_seq + 8'd1;
    push(cyc + 5, {tag, "_hold"}, 0, old_w, 32'hFFFF_FFFF);
    push(cyc + 6, tag, 0, m_word(), 32'hFFFF_FFFF);
    push(cyc + 6, {tag, "_pend"}, 2, m_pend(), 32'h1);
    tick(8);
  endtask

  task automatic apply_ack(input logic [31:0] word, input string tag);
    ack_word = word;
    if (word[31] != m_ack_seen) begin
      m_ack_seen = word[31];
      m_prs = m_prs & ~word[7:4];
      m_rel = m_rel & ~word[11:8];
      m_ovf = m_ovf & ~word[15:12];
    end
    push(cyc + 1, tag, 0, m_word(), 32'hFFFF_FFFF);
    push(cyc + 1, {tag, "_pend"}, 2, m_pend(), 32'h1);
    tick(3);
  endtask

  initial begin
    reset_n  = 1'b0;
    key_n    = 4'hF;
    sw       = '0;
    ack_word = '0;
    m_reset();
    tick(3);
    push(cyc, "rst_btn", 0, 32'h0, 32'hFFFF_FFFF);
    push(cyc, "rst_sw", 1, 32'h0, 32'hFFFF_FFFF);
    push(cyc, "rst_pend", 2, 32'h0, 32'h1);
    tick(1);
    reset_n = 1'b1;
    tick(2);

    apply_keys(4'hE, "k0_press");

    key_n = 4'hF;
    tick(3);
    key_n = 4'hE;
    push(cyc + 3, "glitch_mid", 0, m_word(), 32'hFFFF_FFFF);
    push(cyc + 6, "glitch_rej", 0, m_word(), 32'hFFFF_FFFF);
    tick(8);

    apply_keys(4'hC, "k1_press");
    apply_keys(4'hE, "k1_rel");
    apply_keys(4'hC, "k1_ovf");

    apply_ack(32'h8000_0020, "ack_prs1");
    apply_ack(32'h8000_0020, "ack_same");
    apply_ack(32'h0000_2200, "ack_rel_ovf");
    apply_ack(32'h0000_0010, "ack_notoggle");

    apply_keys(4'h8, "k2_press");
    apply_keys(4'hC, "k2_rel");
    key_n = 4'h8;
    tick(5);
    ack_word = 32'h8000_0040;
    m_lvl[2]   = 1'b1;
    m_seq      = m_seq + 8'd1;
    m_ack_seen = 1'b1;
    push(cyc + 1, "evt_vs_clr", 0, m_word(), 32'hFFFF_FFFF);
    push(cyc + 1, "evt_vs_clr_pend", 2, m_pend(), 32'h1);
    tick(3);

    sw = 18'h2AAAA;
    push(cyc + 5, "sw_hold", 1, 32'h0, 32'hFFFF_FFFF);
    push(cyc + 6, "sw_lvl", 1, 32'h0002_AAAA, 32'hFFFF_FFFF);
    push(cyc + 6, "sw_noevt", 0, m_word(), 32'hFFFF_FFFF);
    tick(8);

    while (m_seq != 8'd0) apply_keys(key_n ^ 4'b1000, "wrap");
    push(cyc, "seq_wrap", 0, 32'h0, 32'h00FF_0000);
    tick(2);

    sw = '0;
    tick(3);
    reset_n  = 1'b0;
    key_n    = 4'hF;
    ack_word = '0;
    m_reset();
    #1;
    push(cyc, "midrst_btn", 0, 32'h0, 32'hFFFF_FFFF);
    push(cyc, "midrst_sw", 1, 32'h0, 32'hFFFF_FFFF);
    push(cyc, "midrst_pend", 2, 32'h0, 32'h1);
    tick(2);
    reset_n = 1'b1;
    push(cyc + 8, "postrst_btn", 0, 32'h0, 32'hFFFF_FFFF);
    push(cyc + 8, "postrst_sw", 1, 32'h0, 32'hFFFF_FFFF);
    push(cyc + 8, "postrst_pend", 2, 32'h0, 32'h1);
    tick(10);

    for (int i = 0; i < 50 && sb_q.size() > 0; i++) tick(1);
    chk_val("sb_drain", 32'(sb_q.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
